seq_magnitude_comparator: RTL and testbench



---
 rtl/seq_magnitude_comparator_if.sv | 25 ++
 rtl/seq_magnitude_comparator.sv | 170 +++++++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand bundle for seq_magnitude_comparator.
// master: requester (drives start/operands); slave: the comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK
// bits per clock, most significant chunk first, signed or unsigned.
// Optional build macro SEQ_MAGCMP_EARLY_EXIT_EN: stop at the first differing
// chunk (data-dependent latency). Without it, latency is always NCHUNK cycles.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  seq_magnitude_comparator_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_magnitude_comparator: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gt_q, gt_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
`ifndef SEQ_MAGCMP_EARLY_EXIT_EN
  logic              decided_q, decided_d;
  logic              pend_gt_q, pend_gt_d;
  logic              pend_lt_q, pend_lt_d;
  logic              res_gt, res_lt;
`endif

  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              chunk_gt, chunk_lt;

  // Next-state, operand capture and result registration.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
`ifndef SEQ_MAGCMP_EARLY_EXIT_EN
    decided_d = decided_q;
    pend_gt_d = pend_gt_q;
    pend_lt_d = pend_lt_q;
    res_gt    = 1'b0;
    res_lt    = 1'b0;
`endif

    chunk_a  = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b  = b_q[idx_q*CHUNK +: CHUNK];
    chunk_gt = chunk_a > chunk_b;
    chunk_lt = chunk_a < chunk_b;

    case (state_q)
      IDLE, FINISH: begin
        if (bus.start) begin
          // Signed compare folded into capture: flipping both sign bits once
          // here equals flipping them before the top-chunk compare.
          a_d     = bus.a ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
          b_d     = bus.b ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
          idx_d   = IDXW'(NCHUNK - 1);
          state_d = COMPARE;
          busy_d  = 1'b1;
`ifndef SEQ_MAGCMP_EARLY_EXIT_EN
          decided_d = 1'b0;
          pend_gt_d = 1'b0;
          pend_lt_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      COMPARE: begin
`ifdef SEQ_MAGCMP_EARLY_EXIT_EN
        if (chunk_gt || chunk_lt || idx_q == '0) begin
          gt_d    = chunk_gt;
          lt_d    = chunk_lt;
          eq_d    = !(chunk_gt || chunk_lt);
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`else
        // Once a chunk differs its verdict is frozen; lower chunks are only
        // stepped through to keep latency constant.
        res_gt = decided_q ? pend_gt_q : chunk_gt;
        res_lt = decided_q ? pend_lt_q : chunk_lt;
        if (!decided_q && (chunk_gt || chunk_lt)) begin
          decided_d = 1'b1;
          pend_gt_d = chunk_gt;
          pend_lt_d = chunk_lt;
        end
        if (idx_q == '0) begin
          gt_d    = res_gt;
          lt_d    = res_lt;
          eq_d    = !(res_gt || res_lt);
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset discards any compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
      lt_q    <= 1'b0;
`ifndef SEQ_MAGCMP_EARLY_EXIT_EN
      decided_q <= 1'b0;
      pend_gt_q <= 1'b0;
      pend_lt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
`ifndef SEQ_MAGCMP_EARLY_EXIT_EN
      decided_q <= decided_d;
      pend_gt_q <= pend_gt_d;
      pend_lt_q <= pend_lt_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench for seq_magnitude_comparator (WIDTH=16, CHUNK=4).
module tb_seq_magnitude_comparator;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_vec     = 0;
  int   n_miscmp  = 0;
  logic exp_gt    = 1'b0;
  logic exp_eq    = 1'b1;
  logic exp_lt    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic busy, input logic done);
    check({tag, "/busy"}, 32'(bus.busy), 32'(busy));
    check({tag, "/done"}, 32'(bus.done), 32'(done));
    check({tag, "/gt"},   32'(bus.gt),   32'(exp_gt));
    check({tag, "/eq"},   32'(bus.eq),   32'(exp_eq));
    check({tag, "/lt"},   32'(bus.lt),   32'(exp_lt));
  endtask

  // Reference latency: early exit stops at the highest differing chunk.
  function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SEQ_MAGCMP_EARLY_EXIT_EN
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] cmask;
    diff  = a ^ b;
    cmask = WIDTH'((1 << CHUNK) - 1);
    for (int unsigned k = NCHUNK; k > 0; k--) begin
      if (((diff >> ((k - 1) * CHUNK)) & cmask) != '0)
        return int'(NCHUNK + 1 - k);
    end
    return NCHUNK;
`else
    return NCHUNK + 0 * int'(a ^ b);
`endif
  endfunction

  task automatic scramble();
    bus.a           = 16'($urandom);
    bus.b           = 16'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  // Issue one compare from IDLE or FINISH; returns at the done cycle.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sm, input logic repulse);
    logic signed [WIDTH-1:0] sa, sb;
    logic ngt, nlt;
    int   lat;
    bit   seen;
    sa = a;
    sb = b;
    if (sm) begin
      ngt = sa > sb;
      nlt = sa < sb;
    end else begin
      ngt = a > b;
      nlt = a < b;
    end
    lat = ref_latency(a, b);

    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.signed_mode = sm;
    step();
    bus.start = 1'b0;
    scramble();
    check_outs("accept", 1'b1, 1'b0);

    seen = 0;
    for (int c = 1; c <= NCHUNK + 2 && !seen; c++) begin
      step();
      bus.start = 1'b0;
      scramble();
      if (bus.done === 1'b1) begin
        seen = 1;
        check("latency", 32'(c), 32'(lat));
        exp_gt = ngt;
        exp_lt = nlt;
        exp_eq = !(ngt || nlt);
        check_outs("result", 1'b0, 1'b1);
      end else begin
        check_outs("wait", 1'b1, 1'b0);
        if (repulse && c == 1) begin
          bus.start = 1'b1;
          bus.a = 16'hFFFF;
          bus.b = 16'h0000;
        end
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle();
    step();
    check_outs("idle", 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    #12;
    check_outs("reset", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    idle_cycle();

    // Directed cases
    run_cmp(16'h1234, 16'h1234, 1'b0, 1'b0); idle_cycle();
    run_cmp(16'h8000, 16'h7FFF, 1'b0, 1'b0); idle_cycle();
    run_cmp(16'h8000, 16'h7FFF, 1'b1, 1'b0); idle_cycle();
    run_cmp(16'h1235, 16'h1234, 1'b0, 1'b0); idle_cycle();
    run_cmp(16'hFFFE, 16'hFFFF, 1'b1, 1'b0); idle_cycle();
    run_cmp(16'h0001, 16'h0002, 1'b0, 1'b1); idle_cycle();
    // Back-to-back: second start issued in the FINISH cycle
    run_cmp(16'h0010, 16'h0020, 1'b0, 1'b0);
    run_cmp(16'h7000, 16'h1000, 1'b0, 1'b0);
    run_cmp(16'h4444, 16'h4444, 1'b1, 1'b0); idle_cycle();

    // Reset during COMPARE with idx==2
    run_cmp(16'h5000, 16'h1000, 1'b0, 1'b0); idle_cycle();
    bus.start = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h1234;
    bus.signed_mode = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    check_outs("pre_reset", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_gt = 1'b0;
    exp_eq = 1'b1;
    exp_lt = 1'b0;
    check_outs("reset_mid", 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      step();
      check_outs("post_reset", 1'b0, 1'b0);
    end

    // Randomised compares with biased operand relationships
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      case ($urandom % 4)
        0: rb = 16'($urandom);
        1: rb = ra;
        2: rb = ra ^ (16'h1 << ($urandom % WIDTH));
        default: rb = {ra[WIDTH-1:8], 8'($urandom)};
      endcase
      run_cmp(ra, rb, 1'($urandom), ($urandom % 4) == 0);
      if ($urandom % 2) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
